// File: rtl/fetch_stall_controller_pkg.sv
// Shared types for the fetch stall controller: state encoding, command bundle.
// Optional statistics counters are enabled with the STALL_STATS_EN macro.
package fetch_stall_controller_pkg;

   typedef enum logic [1:0] {
      ST_FILL  = 2'd0,
      ST_RUN   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_FLUSH = 2'd3
   } fetch_state_e;

   localparam logic [31:0] NOP_WORD = 32'h0000_0000;

   localparam int FLUSH_CNT_W = 3;
   localparam int HOLD_CNT_W  = 8;

   typedef struct packed {
      logic ir_stall;
      logic ir_flush;
      logic pc_enable;
      logic pc_load;
      logic fetch_valid;
   } fetch_cmd_t;

   localparam fetch_cmd_t CMD_RESET = '{
      ir_stall: 1'b1, ir_flush: 1'b1, pc_enable: 1'b0,
      pc_load: 1'b0, fetch_valid: 1'b0};

   localparam fetch_cmd_t CMD_FILL = '{
      ir_stall: 1'b0, ir_flush: 1'b1, pc_enable: 1'b1,
      pc_load: 1'b0, fetch_valid: 1'b0};

   localparam fetch_cmd_t CMD_ADV = '{
      ir_stall: 1'b0, ir_flush: 1'b0, pc_enable: 1'b1,
      pc_load: 1'b0, fetch_valid: 1'b1};

   localparam fetch_cmd_t CMD_HOLD = '{
      ir_stall: 1'b1, ir_flush: 1'b0, pc_enable: 1'b0,
      pc_load: 1'b0, fetch_valid: 1'b0};

   localparam fetch_cmd_t CMD_BRANCH = '{
      ir_stall: 1'b0, ir_flush: 1'b1, pc_enable: 1'b0,
      pc_load: 1'b1, fetch_valid: 1'b0};

   localparam fetch_cmd_t CMD_FLUSH = '{
      ir_stall: 1'b0, ir_flush: 1'b1, pc_enable: 1'b1,
      pc_load: 1'b0, fetch_valid: 1'b0};

   localparam fetch_cmd_t CMD_FLUSH_WAIT = '{
      ir_stall: 1'b0, ir_flush: 1'b1, pc_enable: 1'b0,
      pc_load: 1'b0, fetch_valid: 1'b0};

endpackage

// File: rtl/fetch_stall_controller_if.sv
// Request/command bundle between the fetch controller and the pipeline.
// Statistics ports exist in every build; STALL_STATS_EN decides if they count.
interface fetch_stall_controller_if #(
   parameter int STAT_W = 16
);
   logic              mem_busy;
   logic              data_hazard;
   logic              branch_taken;
   logic              ir_stall;
   logic              ir_flush;
   logic              pc_enable;
   logic              pc_load;
   logic              fetch_valid;
   logic              hang_error;
   logic [STAT_W-1:0] stall_cycles;
   logic [STAT_W-1:0] flush_cycles;

   modport master (
      input  mem_busy, data_hazard, branch_taken,
      output ir_stall, ir_flush, pc_enable, pc_load,
      output fetch_valid, hang_error,
      output stall_cycles, flush_cycles
   );

   modport slave (
      output mem_busy, data_hazard, branch_taken,
      input  ir_stall, ir_flush, pc_enable, pc_load,
      input  fetch_valid, hang_error,
      input  stall_cycles, flush_cycles
   );
endinterface

// File: rtl/fetch_stall_controller_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Shared by the hold watchdog and the STALL_STATS_EN statistics counters.
module sat_counter #(
   parameter int           W   = 8,
   parameter logic [W-1:0] MAX = '1
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o
);
   logic [W-1:0] cnt_q, cnt_d;

   // Next count: clear, else step until the ceiling.
   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != MAX)) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign count_o = cnt_q;
endmodule

// File: rtl/fetch_stall_controller.sv
// Fetch sequencing: merges memory/hazard/branch requests into IR and PC commands.
// Define STALL_STATS_EN to enable the stall/flush statistics counters.
module fetch_stall_controller
   import fetch_stall_controller_pkg::*;
#(
   parameter int BRANCH_PENALTY = 2,
   parameter int HOLD_LIMIT     = 64,
   parameter int STAT_W         = 16
) (
   input logic                      clock,
   input logic                      reset,
   fetch_stall_controller_if.master bus
);
   localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD =
      FLUSH_CNT_W'(BRANCH_PENALTY - 1);
   localparam logic [HOLD_CNT_W-1:0] HOLD_MAX =
      HOLD_CNT_W'(HOLD_LIMIT);
   localparam logic [HOLD_CNT_W-1:0] HOLD_TRIP =
      HOLD_CNT_W'(HOLD_LIMIT - 1);
   localparam fetch_state_e BR_NEXT =
      (BRANCH_PENALTY > 1) ? ST_FLUSH : ST_RUN;

   fetch_state_e           state_q, state_d;
   logic [FLUSH_CNT_W-1:0] flush_cnt_q, flush_cnt_d;
   logic [HOLD_CNT_W-1:0]  hold_cnt;
   logic                   hang_q;
   logic                   hang_set;
   logic                   req_hold;
   logic                   stall_evt;
   fetch_cmd_t             cmd;

   assign req_hold = bus.mem_busy | bus.data_hazard;

   // Mealy command and next state; reset forces the reset command at once.
   always_comb begin
      state_d     = state_q;
      flush_cnt_d = flush_cnt_q;
      cmd         = CMD_ADV;
      unique case (state_q)
         ST_FILL: begin
            cmd     = CMD_FILL;
            state_d = ST_RUN;
         end
         ST_RUN, ST_HOLD: begin
            if (bus.branch_taken) begin
               cmd         = CMD_BRANCH;
               state_d     = BR_NEXT;
               flush_cnt_d = FLUSH_LOAD;
            end else if (req_hold) begin
               cmd     = CMD_HOLD;
               state_d = ST_HOLD;
            end else begin
               cmd     = CMD_ADV;
               state_d = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (bus.branch_taken) begin
               cmd         = CMD_BRANCH;
               state_d     = BR_NEXT;
               flush_cnt_d = FLUSH_LOAD;
            end else if (bus.mem_busy) begin
               cmd = CMD_FLUSH_WAIT;
            end else begin
               cmd         = CMD_FLUSH;
               flush_cnt_d = flush_cnt_q - FLUSH_CNT_W'(1);
               if (flush_cnt_q <= FLUSH_CNT_W'(1)) begin
                  state_d = ST_RUN;
               end
            end
         end
         default: begin
            state_d = ST_FILL;
         end
      endcase
      if (reset) begin
         cmd = CMD_RESET;
      end
   end

   // State and flush countdown registers.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_FILL;
         flush_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   // A stall cycle is any cycle the IR is held on request.
   assign stall_evt = cmd.ir_stall & ~reset;

   sat_counter #(
      .W   (HOLD_CNT_W),
      .MAX (HOLD_MAX)
   ) u_hold_cnt (
      .clock   (clock),
      .reset   (reset),
      .inc_i   (stall_evt),
      .clr_i   (~stall_evt),
      .count_o (hold_cnt)
   );

   assign hang_set = stall_evt && (hold_cnt >= HOLD_TRIP);

   // Sticky watchdog flag.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         hang_q <= 1'b0;
      end else begin
         hang_q <= hang_q | hang_set;
      end
   end

`ifdef STALL_STATS_EN
   logic              flush_evt;
   logic [STAT_W-1:0] stall_stat;
   logic [STAT_W-1:0] flush_stat;

   assign flush_evt = cmd.ir_flush & ~reset;

   sat_counter #(
      .W (STAT_W)
   ) u_stall_stat (
      .clock   (clock),
      .reset   (reset),
      .inc_i   (stall_evt),
      .clr_i   (1'b0),
      .count_o (stall_stat)
   );

   sat_counter #(
      .W (STAT_W)
   ) u_flush_stat (
      .clock   (clock),
      .reset   (reset),
      .inc_i   (flush_evt),
      .clr_i   (1'b0),
      .count_o (flush_stat)
   );

   assign bus.stall_cycles = stall_stat;
   assign bus.flush_cycles = flush_stat;
`else
   assign bus.stall_cycles = STAT_W'(0);
   assign bus.flush_cycles = STAT_W'(0);
`endif

   assign bus.ir_stall    = cmd.ir_stall;
   assign bus.ir_flush    = cmd.ir_flush;
   assign bus.pc_enable   = cmd.pc_enable;
   assign bus.pc_load     = cmd.pc_load;
   assign bus.fetch_valid = cmd.fetch_valid;
   assign bus.hang_error  = hang_q;
endmodule
